fmac_norm: RTL and testbench

- Normalization stage of the FMAC datapath, directly downstream of the leading-zero anticipator.
- Consumes the adder magnitude, the anticipated leading-zero count and the pre-normalization exponent.
- Left-shifts the magnitude, corrects the one-position LZA under-prediction and clamps to the subnormal range.
- Emits mantissa, round bit, sticky bit and exponent to the rounding stage through a 2-stage valid/ready pipeline.

---
 rtl/fmac_norm_pkg.sv | 17 +
 rtl/fmac_norm_shift.sv | 40 ++++
 rtl/fmac_norm.sv | 130 +++++++++++++
 tb/tb_fmac_norm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fmac_norm_pkg.sv
// Shared FMAC definitions for the normalization stage and its neighbours.
package fpu_defs_fmac;

    localparam int unsigned C_LEADONE_WIDTH = 7;
    localparam int unsigned C_EXP           = 10;
    localparam int unsigned C_MANT          = 24;

    // Stage-2 register contents, handed to the rounding stage.
    typedef struct packed {
        logic [C_MANT-1:0] mant;
        logic              round;
        logic              sticky;
        logic [C_EXP-1:0]  exp;
        logic              zero;
    } norm_out_t;

endpackage

// File: rtl/fmac_norm_shift.sv
// Stage-1 barrel left shift: picks the shift amount from the LZA count,
// limited so the exponent never drops below the subnormal boundary.
module fmac_norm_shift #(
    parameter int unsigned C_WIDTH         = 74,
    parameter int unsigned C_LEADONE_WIDTH = 7,
    parameter int unsigned C_EXP           = 10
) (
    input  logic [C_WIDTH-1:0]         Sum_DI,
    input  logic [C_LEADONE_WIDTH-1:0] Lz_DI,
    input  logic [C_EXP-1:0]           Exp_DI,
    output logic [C_WIDTH-1:0]         Sum_DO,
    output logic [C_EXP-1:0]           Exp_DO,
    output logic                       Clamp_SO
);

    localparam logic signed [C_EXP:0] ONE = (C_EXP+1)'(1);

    logic signed [C_EXP:0] exp_ext;
    logic signed [C_EXP:0] diff;
    logic [C_EXP-1:0]      sh;

    always_comb begin
        exp_ext  = {Exp_DI[C_EXP-1], Exp_DI};
        diff     = exp_ext - $signed({{(C_EXP+1-C_LEADONE_WIDTH){1'b0}}, Lz_DI});
        sh       = '0;
        Clamp_SO = 1'b1;
        if (exp_ext < ONE) begin
            sh = '0;
        end else if (diff < ONE) begin
            // Shift only as far as exponent 1; the result is subnormal.
            sh = Exp_DI - C_EXP'(1);
        end else begin
            sh       = C_EXP'(Lz_DI);
            Clamp_SO = 1'b0;
        end
        Sum_DO = Sum_DI << sh;
        Exp_DO = Clamp_SO ? '0 : diff[C_EXP-1:0];
    end

endmodule

// File: rtl/fmac_norm.sv
// FMAC normalization stage: LZA-driven shift, one-bit under-prediction fix,
// subnormal clamp; two-stage valid/ready pipeline towards rounding.
module fmac_norm #(
    parameter int unsigned C_WIDTH         = 74,
    parameter int unsigned C_LEADONE_WIDTH = fpu_defs_fmac::C_LEADONE_WIDTH,
    parameter int unsigned C_MANT          = fpu_defs_fmac::C_MANT,
    parameter int unsigned C_EXP           = fpu_defs_fmac::C_EXP
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic                       Valid_SI,
    output logic                       Ready_SO,
    input  logic [C_WIDTH-1:0]         Sum_DI,
    input  logic [C_LEADONE_WIDTH-1:0] Leading_one_DI,
    input  logic                       No_one_SI,
    input  logic [C_EXP-1:0]           Exp_DI,
    input  logic                       Flush_SI,
    output logic                       Valid_SO,
    input  logic                       Ready_SI,
    output logic [C_MANT-1:0]          Mant_DO,
    output logic                       Round_SO,
    output logic                       Sticky_SO,
    output logic [C_EXP-1:0]           Exp_DO,
    output logic                       Zero_SO
);
    import fpu_defs_fmac::*;

    logic               v1_q, v1_d, v2_q, v2_d;
    logic [C_WIDTH-1:0] s1_q, s1_d;
    logic [C_EXP-1:0]   e1_q, e1_d;
    logic               clamp_q, clamp_d, zero_q, zero_d;
    norm_out_t          out_q, out_d, norm_res;

    logic               load1, load2;
    logic [C_WIDTH-1:0] sh_sum, s2;
    logic [C_EXP-1:0]   sh_exp, e2;
    logic               sh_clamp;

    fmac_norm_shift #(
        .C_WIDTH        (C_WIDTH),
        .C_LEADONE_WIDTH(C_LEADONE_WIDTH),
        .C_EXP          (C_EXP)
    ) u_shift (
        .Sum_DI  (Sum_DI),
        .Lz_DI   (Leading_one_DI),
        .Exp_DI  (Exp_DI),
        .Sum_DO  (sh_sum),
        .Exp_DO  (sh_exp),
        .Clamp_SO(sh_clamp)
    );

    always_comb begin
        s2 = s1_q;
        e2 = e1_q;
        // LZA may under-predict by one; below exponent 2 the fix would go
        // subnormal, so the value stays put and the exponent becomes 0.
        if (!clamp_q && !s1_q[C_WIDTH-1]) begin
            if (e1_q > C_EXP'(1)) begin
                s2 = s1_q << 1;
                e2 = e1_q - C_EXP'(1);
            end else begin
                e2 = '0;
            end
        end
        norm_res.mant   = s2[C_WIDTH-1 -: C_MANT];
        norm_res.round  = s2[C_WIDTH-1-C_MANT];
        norm_res.sticky = |s2[C_WIDTH-2-C_MANT:0];
        norm_res.exp    = e2;
        norm_res.zero   = 1'b0;
        if (zero_q) begin
            norm_res      = '0;
            norm_res.zero = 1'b1;
        end
    end

    always_comb begin
        load2   = !v2_q || Ready_SI;
        load1   = !v1_q || load2;
        v1_d    = v1_q;
        v2_d    = v2_q;
        s1_d    = s1_q;
        e1_d    = e1_q;
        clamp_d = clamp_q;
        zero_d  = zero_q;
        out_d   = out_q;
        if (Flush_SI) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            if (load2) v2_d = v1_q;
            if (load1) v1_d = Valid_SI;
            if (load1 && Valid_SI) begin
                s1_d    = sh_sum;
                e1_d    = sh_exp;
                clamp_d = sh_clamp;
                zero_d  = No_one_SI || (Sum_DI == '0);
            end
            if (load2 && v1_q) out_d = norm_res;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s1_q    <= '0;
            e1_q    <= '0;
            clamp_q <= 1'b0;
            zero_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            s1_q    <= s1_d;
            e1_q    <= e1_d;
            clamp_q <= clamp_d;
            zero_q  <= zero_d;
            out_q   <= out_d;
        end
    end

    assign Ready_SO  = load1;
    assign Valid_SO  = v2_q;
    assign Mant_DO   = out_q.mant;
    assign Round_SO  = out_q.round;
    assign Sticky_SO = out_q.sticky;
    assign Exp_DO    = out_q.exp;
    assign Zero_SO   = out_q.zero;

endmodule

// File: tb/tb_fmac_norm.sv
// Directed-vector bench for fmac_norm: datapath cases, backpressure, flush, reset.
module tb_fmac_norm;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, no_one, flush, valid_o, ready_i;
    logic [73:0] sum;
    logic [6:0]  lz;
    logic [9:0]  exp_i, exp_o;
    logic [23:0] mant;
    logic        rnd, sticky, zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fmac_norm #(
        .C_WIDTH        (74),
        .C_LEADONE_WIDTH(7),
        .C_MANT         (24),
        .C_EXP          (10)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .Valid_SI      (valid_i),
        .Ready_SO      (ready_o),
        .Sum_DI        (sum),
        .Leading_one_DI(lz),
        .No_one_SI     (no_one),
        .Exp_DI        (exp_i),
        .Flush_SI      (flush),
        .Valid_SO      (valid_o),
        .Ready_SI      (ready_i),
        .Mant_DO       (mant),
        .Round_SO      (rnd),
        .Sticky_SO     (sticky),
        .Exp_DO        (exp_o),
        .Zero_SO       (zero)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    task automatic run_vec(input string tag, input logic [73:0] s, input logic [6:0] l,
                           input logic [9:0] e, input logic n,
                           input logic [23:0] m, input logic r, input logic st,
                           input logic [9:0] eo, input logic z);
        @(negedge clk);
        sum = s; lz = l; exp_i = e; no_one = n; valid_i = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        chk({tag, "/lat1"}, valid_o, 1'b0);
        @(negedge clk);
        chk({tag, "/valid"},  valid_o, 1'b1);
        chk({tag, "/mant"},   mant, m);
        chk({tag, "/round"},  rnd, r);
        chk({tag, "/sticky"}, sticky, st);
        chk({tag, "/exp"},    exp_o, eo);
        chk({tag, "/zero"},   zero, z);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pat;
        int acc, emit, occ, xin, xout;

        rst = 1'b1; valid_i = 1'b0; no_one = 1'b0; flush = 1'b0; ready_i = 1'b0;
        sum = '0; lz = '0; exp_i = '0;
        repeat (3) @(negedge clk);
        chk("rst/valid",  valid_o, 1'b0);
        chk("rst/mant",   mant, 24'h0);
        chk("rst/exp",    exp_o, 10'h0);
        chk("rst/zero",   zero, 1'b0);
        chk("rst/ready",  ready_o, 1'b1);
        rst = 1'b0;

        run_vec("norm",    74'd1 << 73, 7'd0,  10'd100, 1'b0, 24'h800000, 1'b0, 1'b0, 10'd100, 1'b0);
        run_vec("underp",  74'd1 << 63, 7'd9,  10'd100, 1'b0, 24'h800000, 1'b0, 1'b0, 10'd90,  1'b0);
        run_vec("exactlz", 74'd1 << 63, 7'd10, 10'd100, 1'b0, 24'h800000, 1'b0, 1'b0, 10'd90,  1'b0);
        // sh=4 moves bit 53 to bit 57, which is mantissa bit 7.
        run_vec("subclamp", 74'd1 << 53, 7'd20, 10'd5, 1'b0, 24'h000080, 1'b0, 1'b0, 10'd0, 1'b0);
        run_vec("negexp", (74'd1 << 40) | 74'd5, 7'd3, -10'sd3, 1'b0, 24'h000000, 1'b0, 1'b1, 10'd0, 1'b0);
        run_vec("rndstk", (74'd1 << 73) | (74'd1 << 49) | 74'd1, 7'd0, 10'd1, 1'b0,
                24'h800000, 1'b1, 1'b1, 10'd1, 1'b0);
        run_vec("e1fix",  74'd1 << 72, 7'd0, 10'd1, 1'b0, 24'h400000, 1'b0, 1'b0, 10'd0, 1'b0);
        run_vec("bigsh",  74'd1, 7'd120, 10'd100, 1'b0, 24'h000000, 1'b0, 1'b0, 10'd0, 1'b0);
        run_vec("noone",  74'd1 << 73, 7'd0, 10'd100, 1'b1, 24'h000000, 1'b0, 1'b0, 10'd0, 1'b1);
        run_vec("sumzero", 74'd0, 7'd0, 10'd100, 1'b0, 24'h000000, 1'b0, 1'b0, 10'd0, 1'b1);
        run_vec("expmax", 74'd1 << 73, 7'd0, 10'd511, 1'b0, 24'h800000, 1'b0, 1'b0, 10'd511, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: Ready_SI cycles 1,0,0,1; occ models ops held in the pipe.
        pat = 4'b1001;
        acc = 0; emit = 0; occ = 0;
        for (int cyc = 0; cyc < 80 && emit < 8; cyc++) begin
            @(negedge clk);
            ready_i = pat[cyc % 4];
            valid_i = (acc < 8);
            sum = 74'd1 << 73; lz = 7'd0; no_one = 1'b0; exp_i = 10'(10 + acc);
            #1;
            chk("bp/ready", ready_o, !(occ == 2 && !ready_i));
            xin  = (valid_i && ready_o) ? 1 : 0;
            xout = (valid_o && ready_i) ? 1 : 0;
            if (xout == 1) chk("bp/order", exp_o, 10'(10 + emit));
            @(posedge clk);
            occ  = occ + xin - xout;
            acc  = acc + xin;
            emit = emit + xout;
        end
        chk("bp/count", emit, 8);
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk);

        // Flush with two ops in flight and a third presented.
        valid_i = 1'b1; ready_i = 1'b0; exp_i = 10'd50;
        @(negedge clk);
        exp_i = 10'd51;
        @(negedge clk);
        chk("fl/full", valid_o, 1'b1);
        exp_i = 10'd52; flush = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        chk("fl/valid0", valid_o, 1'b0);
        flush = 1'b0; valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl/quiet", valid_o, 1'b0);
        end

        // Reset mid-stream.
        valid_i = 1'b1; ready_i = 1'b1; exp_i = 10'd60; sum = (74'd1 << 73) | (74'd1 << 49) | 74'd1;
        @(negedge clk);
        exp_i = 10'd61;
        @(negedge clk);
        chk("rs/pre", exp_o, 10'd60);
        rst = 1'b1;
        @(negedge clk);
        chk("rs/valid",  valid_o, 1'b0);
        chk("rs/mant",   mant, 24'h0);
        chk("rs/round",  rnd, 1'b0);
        chk("rs/sticky", sticky, 1'b0);
        chk("rs/exp",    exp_o, 10'h0);
        chk("rs/zero",   zero, 1'b0);
        rst = 1'b0; valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rs/quiet", valid_o, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
